// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph
// Brief    : Memory-mapped UART transmitter with a TX FIFO and a baud-rate FSM.
//            Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        hit,
    output logic        tx,
    output logic        irq
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth   = c_pw'(FIFO_DEPTH);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

`ifdef UART_TX_PARITY_EN
    localparam logic c_par_en = 1'b1;
`else
    localparam logic c_par_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [15:0]     r_baud_cnt;
    logic            r_tx;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic            r_ovf;
    logic [15:0]     r_div;
    logic [7:0]      r_mem [FIFO_DEPTH];

    logic [1:0]      w_sel;
    logic            w_wr_en;
    logic [c_pw-1:0] w_count;
    logic [3:0]      w_count_nib;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_clr;
    logic            w_div_wr;
    logic [15:0]     w_div_eff;
    logic [15:0]     w_baud_load;
    logic            w_expire;
    logic            w_busy;
    logic [7:0]      w_head;
    logic [31:0]     w_status;
    logic            w_unused;

    assign hit         = cs && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = addr[3:2];
    assign w_wr_en     = hit && wr;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_count_nib = 4'(w_count);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (w_count == c_depth);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_push_req  = w_wr_en && (w_sel == 2'd0) && mask[0];
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_clr   = w_wr_en && (w_sel == 2'd1) && mask[0] && data_wr[3];
    assign w_div_wr    = w_wr_en && (w_sel == 2'd2);
    assign w_head      = r_mem[r_rd_ptr[c_aw-1:0]];

    assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_baud_load = w_div_eff - 16'd1;
    assign w_expire    = (r_baud_cnt == 16'd0);
    assign w_busy      = (r_state != S_IDLE);

    assign w_status = {20'd0, w_count_nib, 3'd0, c_par_en, r_ovf, w_empty, w_full, w_busy};
    assign w_unused = &{1'b0, addr[1:0], data_wr[31:16], mask[3:2]};

    assign tx  = r_tx;
    assign irq = w_empty && (r_state == S_IDLE);

    always_comb begin
        data_rd = 32'd0;
        if (hit && !wr) begin
            case (w_sel)
                2'd1:    data_rd = w_status;
                2'd2:    data_rd = {16'd0, r_div};
                default: data_rd = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= data_wr[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_div    <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_div_wr && mask[0]) begin
                r_div[7:0] <= data_wr[7:0];
            end
            if (w_div_wr && mask[1]) begin
                r_div[15:8] <= data_wr[15:8];
            end
        end
    end

    // Every bit start reloads the baud counter from the live divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_par      <= ^w_head;
`endif
                        r_bit_cnt  <= 3'd0;
                        r_baud_cnt <= w_baud_load;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        r_baud_cnt <= w_baud_load;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_baud_cnt <= w_baud_load;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_expire) begin
                        r_baud_cnt <= w_baud_load;
                        r_tx       <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_expire) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_periph
// Brief    : Scoreboard bench for uart_tx_periph: frame monitor plus directed
//            line-waveform, status, overflow and reset checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

    localparam logic [31:0] c_base = 32'h8000_0000;
`ifdef UART_TX_PARITY_EN
    localparam int c_par = 1;
`else
    localparam int c_par = 0;
`endif
    localparam int          c_nbits  = 10 + c_par;
    localparam logic [31:0] c_par_st = 32'(c_par << 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        hit;
    logic        tx;
    logic        irq;

    uart_tx_periph dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .wr      (wr),
        .mask    (mask),
        .addr    (addr),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .hit     (hit),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       rec[$];
    logic       rec_en = 1'b0;
    logic       mon_en = 1'b0;
    int         mon_d = 434;
    int         mon_frames = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level of frame bit i: start, 8 data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (c_par == 1 && i == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; data_wr = d; mask = m;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; mask = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        cs = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = data_rd;
        h = hit;
        cs = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, irq, 1);
    endtask

    // rec[0] is the cycle after the store edge; then d0 cycles of start, d per later bit.
    task automatic check_rec(input logic [7:0] b, input int d0, input int d, input string tag);
        int idx;
        int ok;
        int need;
        need = 1 + d0 + (c_nbits - 1) * d;
        check_eq({tag, "_len"}, 32'(rec.size() >= need), 1);
        if (rec.size() < need) return;
        check_eq({tag, "_pre"}, rec[0], 1);
        idx = 1;
        for (int i = 0; i < c_nbits; i++) begin
            int dur = (i == 0) ? d0 : d;
            ok = 0;
            for (int k = 0; k < dur; k++) begin
                if (rec[idx] === frame_bit(b, i)) ok++;
                idx++;
            end
            check_eq($sformatf("%s_bit%0d", tag, i), ok, dur);
        end
    endtask

    always @(negedge clk) begin
        if (rec_en) rec.push_back(tx);
    end

    initial begin : p_mon
        logic [7:0] b;
        logic [7:0] e;
        logic       s;
        int         d;
        int         pos;
        int         tgt;
        b = 8'd0;
        forever begin
            do @(negedge clk); while (!(mon_en && tx === 1'b0));
            d   = mon_d;
            pos = 0;
            for (int i = 0; i < c_nbits; i++) begin
                tgt = i * d + d / 2;
                while (pos < tgt) begin
                    @(negedge clk);
                    pos++;
                end
                s = tx;
                if (i == 0)                check_eq("mon_start", s, 0);
                else if (i <= 8)           b[i-1] = s;
                else if (i == c_nbits - 1) check_eq("mon_stop", s, 1);
                else                       check_eq("mon_parity", s, ^b);
            end
            mon_frames++;
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check_eq("mon_byte", b, e);
            end
        end
    end

    initial begin : p_main
        logic [31:0] rd;
        logic        h;
        int          zeros;
        rst = 1'b1; cs = 1'b0; wr = 1'b0; mask = 4'd0; addr = 32'd0; data_wr = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_irq", irq, 1);
        check_eq("rst_data_rd", data_rd, 0);
        rst = 1'b0;

        bus_read(c_base + 32'h8, rd, h);
        check_eq("rst_div", rd, 434);
        check_eq("base_hit", h, 1);
        bus_read(c_base + 32'h4, rd, h);
        check_eq("rst_status", rd, 32'h4 | c_par_st);
        bus_read(32'h7FFF_FFF0, rd, h);
        check_eq("miss_rd", rd, 0);
        check_eq("miss_hit", h, 0);
        bus_write(c_base + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(c_base + 32'hC, rd, h);
        check_eq("rsvd_rd", rd, 0);
        bus_read(c_base + 32'h8, rd, h);
        check_eq("rsvd_nowrite_div", rd, 434);
        bus_read(c_base + 32'h0, rd, h);
        check_eq("txdata_rd", rd, 0);

        // 0x55 at divider 4
        bus_write(c_base + 32'h8, 32'd4, 4'b0011);
        mon_d = 4; mon_en = 1'b1;
        sb.push_back(8'h55);
        rec.delete();
        bus_write(c_base, 32'h55, 4'b0001);
        rec_en = 1'b1;
        check_eq("t1_irq_low", irq, 0);
        bus_read(c_base + 32'h4, rd, h);
        check_eq("t1_status_cnt1", rd, 32'h100 | c_par_st);
        wait_idle(200, "t1_done");
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        check_rec(8'h55, 4, 4, "t1");

        // divider 0 behaves as 1
        bus_write(c_base + 32'h8, 32'd0, 4'b0011);
        mon_d = 1;
        sb.push_back(8'hA3);
        rec.delete();
        bus_write(c_base, 32'hA3, 4'b0001);
        rec_en = 1'b1;
        wait_idle(100, "t2_done");
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        check_rec(8'hA3, 1, 1, "t2");

        // divider 8 -> 2 while the start bit is on the line
        mon_en = 1'b0;
        bus_write(c_base + 32'h8, 32'd8, 4'b0011);
        rec.delete();
        bus_write(c_base, 32'hC6, 4'b0001);
        rec_en = 1'b1;
        repeat (3) @(posedge clk);
        bus_write(c_base + 32'h8, 32'd2, 4'b0011);
        wait_idle(300, "t3_done");
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        check_rec(8'hC6, 8, 2, "t3");

        // overflow: ten stores in ten cycles, first pops at once, tenth dropped
        bus_write(c_base + 32'h8, 32'd434, 4'b0011);
        mon_d = 434; mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb.push_back(8'(8'h30 + i));
            bus_write(c_base, 32'(32'h30 + i), 4'b0001);
        end
        bus_read(c_base + 32'h4, rd, h);
        check_eq("t4_status_ovf", rd, 32'h80B | c_par_st);
        bus_write(c_base + 32'h4, 32'h8, 4'b0001);
        bus_read(c_base + 32'h4, rd, h);
        check_eq("t4_status_clr", rd, 32'h803 | c_par_st);
        wait_idle(9 * c_nbits * 434 + 200, "t4_done");
        check_eq("t4_frames", mon_frames, 11);
        check_eq("t4_sb_drained", 32'(sb.size()), 0);
        bus_read(c_base + 32'h4, rd, h);
        check_eq("t4_status_end", rd, 32'h4 | c_par_st);

        // reset during data bit 3 of a 0x00 frame with another byte queued
        mon_en = 1'b0;
        bus_write(c_base + 32'h8, 32'd4, 4'b0011);
        bus_write(c_base, 32'h00, 4'b0001);
        bus_write(c_base, 32'hFF, 4'b0001);
        repeat (17) @(posedge clk);
        #2;
        check_eq("t5_pre_tx", tx, 0);
        rst = 1'b1;
        #1;
        check_eq("t5_async_tx", tx, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(c_base + 32'h4, rd, h);
        check_eq("t5_status", rd, 32'h4 | c_par_st);
        check_eq("t5_irq", irq, 1);
        bus_read(c_base + 32'h8, rd, h);
        check_eq("t5_div", rd, 434);
        zeros = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check_eq("t5_quiet", zeros, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
